b_predict_check: RTL

Parametrised branch condition evaluator with a bimodal branch history table (BHT) for the pipelined MIPS core. It provides a prediction to IF from a PC-indexed table of 2-bit saturating counters. It resolves the branch in ID from forwarded `Grs`/`Grt` and flags a mispredict for the redirect/flush logic. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/b_predict_check_pkg.sv | 46 ++++
 rtl/b_predict_check_cond_eval.sv | 33 +++
 rtl/b_predict_check.sv | 89 ++++++++
 3 files changed

// File: rtl/b_predict_check_pkg.sv
// Shared branch-predictor definitions: condition codes, counter encodings, helpers.
`ifndef BEQ
`define BEQ  6'b100000
`endif
`ifndef BGEZ
`define BGEZ 6'b010000
`endif
`ifndef BGTZ
`define BGTZ 6'b001000
`endif
`ifndef BLEZ
`define BLEZ 6'b000100
`endif
`ifndef BLTZ
`define BLTZ 6'b000010
`endif
`ifndef BNE
`define BNE  6'b000001
`endif

package b_predict_check_pkg;

  localparam int unsigned BopW = 6;

  // 2-bit saturating counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // True when exactly one condition-code bit is set
  function automatic logic bop_onehot(input logic [BopW-1:0] bop);
    return (bop != '0) && ((bop & (bop - 6'd1)) == '0);
  endfunction

  // Saturating step of a bimodal counter towards the resolved direction
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/b_predict_check_cond_eval.sv
// Combinational branch condition evaluator; non-one-hot codes resolve not-taken.
module b_cond_eval
  import b_predict_check_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] Grs,
  input  logic [WIDTH-1:0] Grt,
  input  logic [BopW-1:0]  bOp,
  output logic             check
);

  logic neg;
  logic zero;

  assign neg  = Grs[WIDTH-1];
  assign zero = (Grs == '0);

  // Decode the one-hot condition; zero/multi-hot codes fall through to not-taken
  always_comb begin
    check = 1'b0;
    case (bOp)
      `BEQ:    check = (Grs == Grt);
      `BGEZ:   check = ~neg;
      `BGTZ:   check = ~neg & ~zero;
      `BLEZ:   check = neg | zero;
      `BLTZ:   check = neg;
      `BNE:    check = (Grs != Grt);
      default: check = 1'b0;
    endcase
  end

endmodule

// File: rtl/b_predict_check.sv
// Bimodal branch predictor with ID-stage resolution and saturating statistics.
module b_predict_check
  import b_predict_check_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] res_pc,
  input  logic             res_pred_taken,
  input  logic [WIDTH-1:0] Grs,
  input  logic [WIDTH-1:0] Grt,
  input  logic [BopW-1:0]  bOp,
  output logic             check,
  output logic             mispredict,
  output logic [31:0]      br_cnt,
  output logic [31:0]      mis_cnt
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  logic [1:0]      bht_q [BHT_DEPTH];
  logic [31:0]     br_cnt_q, br_cnt_d;
  logic [31:0]     mis_cnt_q, mis_cnt_d;
  logic [IdxW-1:0] pred_idx, res_idx;
  logic [1:0]      ctr_d;
  logic            commit;

  // PC bits outside the word-aligned index are intentionally ignored (untagged table)
  logic unused_pc;
  assign unused_pc = ^{pred_pc[WIDTH-1:IdxW+2], pred_pc[1:0],
                       res_pc[WIDTH-1:IdxW+2], res_pc[1:0]};

  assign pred_idx = pred_pc[IdxW+1:2];
  assign res_idx  = res_pc[IdxW+1:2];

  b_cond_eval #(
    .WIDTH (WIDTH)
  ) u_cond_eval (
    .Grs   (Grs),
    .Grt   (Grt),
    .bOp   (bOp),
    .check (check)
  );

  assign commit     = res_valid & ~stall & bop_onehot(bOp);
  assign mispredict = commit & (check != res_pred_taken);
  // Lookup reads the registered table: same-index commits are not bypassed
  assign pred_taken = bht_q[pred_idx][1];
  assign br_cnt     = br_cnt_q;
  assign mis_cnt    = mis_cnt_q;

  // Next-state for the resolved entry and the saturating statistics
  always_comb begin
    ctr_d     = ctr_step(bht_q[res_idx], check);
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (commit && (br_cnt_q != 32'hFFFF_FFFF)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
      mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  // Table and counter state; reset wins over a coincident commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_q[i] <= CTR_INIT;
      end
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (commit) begin
        bht_q[res_idx] <= ctr_d;
      end
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule
